timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter: CHANNELS, default 4, number of independent timer channels (1..16).
REQ-002 Parameter: WIDTH, default 32, counter and period width in bits (2..32).
REQ-003 Port: CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: NRESET  input  1  asynchronous, active-low reset.
REQ-005 Port: EN  input  CHANNELS  per-channel count enable; 0 pauses the channel.
REQ-006 Port: ONESHOT  input  CHANNELS  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-007 Port: LOAD  input  CHANNELS  per-channel single-cycle restart strobe.
REQ-008 Port: PERIOD  input  CHANNELS*WIDTH  per-channel period P; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 Port: TICK  output  CHANNELS  registered one-cycle terminal-count pulse per channel.
REQ-010 Port: BUSY  output  CHANNELS  1 while the channel is in RUN.
REQ-011 Port: COUNT  output  CHANNELS*WIDTH  current counter value per channel, same packing as PERIOD.
REQ-012 Port: IRQ_CLR  input  CHANNELS  per-channel sticky-flag clear strobe (used only with REQ-030).
REQ-013 Port: IRQ  output  1  OR of all sticky flags (used only with REQ-030).

Function
REQ-014 Each channel SHALL be an independent FSM with states IDLE, RUN, DONE plus an up-counter cnt.
REQ-015 IDLE -> RUN on an edge with EN=1 and P!=0; cnt increments on that same edge.
REQ-016 In RUN with EN=1, each edge: if cnt >= P-1 then cnt <= 0 and a terminal event occurs; else cnt <= cnt+1.
REQ-017 In RUN with EN=0, cnt and state SHALL hold; no terminal event.
REQ-018 Terminal event: TICK is 1 for exactly the one cycle following that edge; periodic channels stay in RUN, so P enabled cycles separate consecutive ticks.
REQ-019 One-shot channel: terminal event moves RUN -> DONE; DONE holds cnt=0, BUSY=0, no further ticks, and ignores EN until LOAD.
REQ-020 P=1 SHALL give a terminal event on every enabled edge (TICK continuously 1 in periodic mode).
REQ-021 P=0 SHALL hold the channel in IDLE with cnt=0; a channel in RUN whose P becomes 0 SHALL return to IDLE with cnt=0 and no tick.
REQ-022 P changed mid-count SHALL take effect on the next edge; if cnt >= new P-1, the next enabled edge is a terminal event (no 2^WIDTH wrap).
REQ-023 LOAD=1 SHALL set cnt <= 0 and state <= RUN (IDLE if P=0), with priority over a coincident terminal event, which is then suppressed.
REQ-024 cnt arithmetic SHALL be unsigned modulo 2^WIDTH; P-1 is computed without underflow given REQ-021.
REQ-025 Channels SHALL NOT interact; simultaneous events on different channels are all honoured on the same edge.

Reset
REQ-026 NRESET=0 SHALL immediately force every channel to IDLE, cnt=0, TICK=0, BUSY=0, COUNT=0, sticky flags=0, IRQ=0, independent of CLOCK.
REQ-027 Reset asserted mid-count or mid-tick SHALL abort that period; no TICK is emitted for it after release.
REQ-028 After NRESET deasserts, the first state change SHALL occur no earlier than the next rising CLOCK edge.

Configuration
REQ-029 Macro TIMER_BANK_IRQ_EN SHALL select the interrupt feature.
REQ-030 Defined: each channel has a sticky flag set on its terminal event and cleared by IRQ_CLR; set wins over coincident clear; IRQ = OR of flags, registered.
REQ-031 Undefined: no flag registers are built, IRQ is tied to 0, IRQ_CLR is ignored; all other behaviour is identical.

Verification
REQ-032 Periodic, P=5, EN=1 held -> TICK pulses on cycles 5, 10, 15 after enable; COUNT sequence 1,2,3,4,0 repeating.
REQ-033 One-shot, P=3, EN=1 -> single TICK at cycle 3, BUSY falls, COUNT=0; LOAD pulse at cycle 10 -> next TICK at cycle 13.
REQ-034 Periodic, P=8, EN dropped for 4 cycles at cnt=3 -> COUNT holds 3; TICK delayed exactly 4 cycles versus uninterrupted run.
REQ-035 P reduced from 100 to 10 at cnt=50 -> terminal event on next enabled edge, then ticks every 10 cycles; P=0 -> BUSY=0, COUNT=0.
REQ-036 LOAD coincident with terminal count, and NRESET pulsed mid-count -> no TICK in either case; all outputs 0 asynchronously during reset.
REQ-037 With TIMER_BANK_IRQ_EN: tick on channel 2 -> IRQ=1 until IRQ_CLR[2]; coincident tick and clear -> IRQ stays 1; without the macro IRQ=0 throughout.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: bank of independent programmable up-counting timers.
// Each channel runs IDLE -> RUN -> (DONE for one-shot) and emits a registered
// one-cycle TICK on every terminal count. COUNT, BUSY and TICK are registered.
// Optional feature: define TIMER_BANK_IRQ_EN to build per-channel sticky
// interrupt flags and a registered IRQ output; without it IRQ is tied low.
module timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                         CLOCK,
  input  logic                         NRESET,
  input  logic [CHANNELS-1:0]          EN,
  input  logic [CHANNELS-1:0]          ONESHOT,
  input  logic [CHANNELS-1:0]          LOAD,
  input  logic [CHANNELS*WIDTH-1:0]    PERIOD,
  output logic [CHANNELS-1:0]          TICK,
  output logic [CHANNELS-1:0]          BUSY,
  output logic [CHANNELS*WIDTH-1:0]    COUNT,
  input  logic [CHANNELS-1:0]          IRQ_CLR,
  output logic                         IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                           state_r     [CHANNELS];
  state_t                           state_nxt_s [CHANNELS];
  logic [CHANNELS-1:0][WIDTH-1:0]   period_s;
  logic [CHANNELS-1:0][WIDTH-1:0]   cnt_r;
  logic [CHANNELS-1:0][WIDTH-1:0]   cnt_nxt_s;
  logic [CHANNELS-1:0]              tick_r;
  logic [CHANNELS-1:0]              tick_nxt_s;
  logic [CHANNELS-1:0]              busy_r;

  // Packed view of PERIOD matches the [i*WIDTH +: WIDTH] channel packing.
  assign period_s = PERIOD;

  // Per-channel next-state, counter and terminal-event decode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      tick_nxt_s[i]  = 1'b0;
      if (LOAD[i]) begin
        // Restart wins over everything, including a coincident terminal count.
        cnt_nxt_s[i] = CNT_ZERO;
        if (period_s[i] == CNT_ZERO) begin
          state_nxt_s[i] = ST_IDLE;
        end else begin
          state_nxt_s[i] = ST_RUN;
        end
      end else if (period_s[i] == CNT_ZERO) begin
        // A zero period parks a live channel in IDLE; a finished one-shot stays DONE.
        cnt_nxt_s[i] = CNT_ZERO;
        if (state_r[i] == ST_DONE) begin
          state_nxt_s[i] = ST_DONE;
        end else begin
          state_nxt_s[i] = ST_IDLE;
        end
      end else begin
        case (state_r[i])
          // The IDLE->RUN edge is itself a counting edge, so P=1 ticks at once.
          ST_IDLE, ST_RUN: begin
            if (EN[i]) begin
              // P-1 cannot underflow here because P is non-zero.
              if (cnt_r[i] >= (period_s[i] - CNT_ONE)) begin
                cnt_nxt_s[i]  = CNT_ZERO;
                tick_nxt_s[i] = 1'b1;
                if (ONESHOT[i]) begin
                  state_nxt_s[i] = ST_DONE;
                end else begin
                  state_nxt_s[i] = ST_RUN;
                end
              end else begin
                cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
                state_nxt_s[i] = ST_RUN;
              end
            end else begin
              state_nxt_s[i] = state_r[i];
              cnt_nxt_s[i]   = cnt_r[i];
            end
          end
          ST_DONE: begin
            cnt_nxt_s[i] = CNT_ZERO;
          end
          default: begin
            state_nxt_s[i] = ST_IDLE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Channel state, counter and registered TICK/BUSY outputs.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= ST_IDLE;
      end
      cnt_r  <= {(CHANNELS*WIDTH){1'b0}};
      tick_r <= {CHANNELS{1'b0}};
      busy_r <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_nxt_s[i];
        busy_r[i]  <= (state_nxt_s[i] == ST_RUN);
      end
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  assign TICK  = tick_r;
  assign BUSY  = busy_r;
  assign COUNT = cnt_r;

`ifdef TIMER_BANK_IRQ_EN
  logic [CHANNELS-1:0] flag_r;
  logic [CHANNELS-1:0] flag_nxt_s;
  logic                irq_r;

  // Sticky flags: a terminal event sets, IRQ_CLR clears, set wins.
  always_comb begin
    flag_nxt_s = tick_nxt_s | (flag_r & ~IRQ_CLR);
  end

  // Flag registers and IRQ, registered from the next flag value so they align.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      flag_r <= {CHANNELS{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      flag_r <= flag_nxt_s;
      irq_r  <= |flag_nxt_s;
    end
  end

  assign IRQ = irq_r;
`else
  logic unused_irq_clr_s;
  assign unused_irq_clr_s = ^IRQ_CLR;
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a driver applies directed and random
// stimulus, advances a behavioural model and queues the expected outputs; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_timer_bank;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [CH-1:0]   en = '0, os = '0, ld = '0, clr = '0;
  logic [CH*W-1:0] per = '0;
  logic [CH-1:0]   tick, busy;
  logic [CH*W-1:0] count;
  logic            irq;

  timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .CLOCK(clk), .NRESET(nrst), .EN(en), .ONESHOT(os), .LOAD(ld),
    .PERIOD(per), .TICK(tick), .BUSY(busy), .COUNT(count),
    .IRQ_CLR(clr), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [CH-1:0]   tick;
    logic [CH-1:0]   busy;
    logic [CH*W-1:0] count;
    logic            irq;
  } exp_t;
  exp_t sb[$];

  // stimulus variables (per channel)
  int pv[CH];
  bit ev[CH], ov[CH], lv[CH], cv[CH];
  // behavioural model: count, whether the channel is running, finished one-shot, sticky flag
  int m_cnt[CH];
  bit m_active[CH], m_done[CH], m_flag[CH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_active[i] = 0; m_done[i] = 0; m_flag[i] = 0;
    end
  endtask

  // Drive the current stimulus, advance the model by one clock edge, queue expectation.
  task automatic apply_push();
    exp_t e;
    bit tk;
    for (int i = 0; i < CH; i++) begin
      en[i] = ev[i]; os[i] = ov[i]; ld[i] = lv[i]; clr[i] = cv[i];
      per[i*W +: W] = W'(pv[i]);
    end
    e.irq = 1'b0;
    for (int i = 0; i < CH; i++) begin
      tk = 0;
      if (lv[i]) begin
        m_cnt[i] = 0; m_active[i] = (pv[i] != 0); m_done[i] = 0;
      end else if (pv[i] == 0) begin
        if (!m_done[i]) m_active[i] = 0;
        m_cnt[i] = 0;
      end else if (m_done[i]) begin
        m_cnt[i] = 0;
      end else if (ev[i]) begin
        if (m_cnt[i] + 1 >= pv[i]) begin
          m_cnt[i] = 0; tk = 1;
          if (ov[i]) begin m_active[i] = 0; m_done[i] = 1; end
          else m_active[i] = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_active[i] = 1;
        end
      end
`ifdef TIMER_BANK_IRQ_EN
      if (tk) m_flag[i] = 1;
      else if (cv[i]) m_flag[i] = 0;
      if (m_flag[i]) e.irq = 1'b1;
`endif
      e.tick[i] = tk;
      e.busy[i] = m_active[i];
      e.count[i*W +: W] = W'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      apply_push();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, 64'(tick), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_irq"}, 64'(irq), 64'd0);
  endtask

  // Reset pulse away from the clock edge; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    nrst = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    nrst = 1'b1;
    apply_push();
  endtask

  task automatic set_ch(input int i, input int p, input bit o, input bit e);
    pv[i] = p; ov[i] = o; ev[i] = e; lv[i] = 0; cv[i] = 0;
  endtask

  // monitor: compare every DUT output cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("tick", 64'(tick), 64'(e.tick));
      check("busy", 64'(busy), 64'(e.busy));
      check("count", 64'(count), 64'(e.count));
      check("irq", 64'(irq), 64'(e.irq));
    end
  end

  initial begin
    for (int i = 0; i < CH; i++) set_ch(i, 0, 0, 0);
    model_reset();
    #2;
    check_zero("por");
    @(negedge clk); #1;
    nrst = 1'b1;
    apply_push();

    // periodic P=5, one-shot P=3, periodic P=8 with pause, periodic P=1
    set_ch(0, 5, 0, 1); set_ch(1, 3, 1, 1); set_ch(2, 8, 0, 1); set_ch(3, 1, 0, 1);
    step(3);
    ev[2] = 0; step(4);
    ev[2] = 1; step(2);
    lv[1] = 1; step(1);
    lv[1] = 0; step(8);

    // period shrinks from 100 to 10 mid-count, then goes to 0
    pv[0] = 100; lv[0] = 1; step(1);
    lv[0] = 0; step(50);
    pv[0] = 10; step(25);
    pv[0] = 0; step(3);
    check("p0_busy", 64'(busy[0]), 64'd0);
    check("p0_count", 64'(count[W-1:0]), 64'd0);

    // LOAD coincident with terminal count suppresses the tick
    set_ch(2, 4, 0, 1); lv[2] = 1; step(1);
    lv[2] = 0; step(3);
    lv[2] = 1; step(1);
    lv[2] = 0; step(2);

    // reset while channel 3 (P=1) is mid-tick
    do_reset("midrun");
    step(4);

    // sticky flag on channel 2: plain clear, then clears coinciding with ticks
    set_ch(2, 2, 0, 1);
    step(6);
    cv[2] = 1; step(1);
    cv[2] = 0; step(3);
    cv[2] = 1; step(4);
    cv[2] = 0; step(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 40) == 0) pv[i] = $urandom_range(0, 12);
        if ($urandom_range(0, 60) == 0) ov[i] = ~ov[i];
        ev[i] = ($urandom_range(0, 7) != 0);
        lv[i] = ($urandom_range(0, 29) == 0);
        cv[i] = ($urandom_range(0, 5) == 0);
      end
      if (c % 1000 == 500) do_reset("rand");
      else step(1);
    end

    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
